// File: rtl/dso_wave_pic.sv
// dso_wave_pic: three-stage oscilloscope renderer. Maps timing-generator
// coordinates into a display window, fetches one wave RAM column per pixel,
// and composes traces, trigger marker, border and graticule into RGB565.
module dso_wave_pic #(
    parameter int H_VALID = 640,
    parameter int V_VALID = 480,
    parameter int WIN_X0  = 20,
    parameter int WIN_Y0  = 20,
    parameter int WIN_W   = 512,
    parameter int DATA_W  = 8,
    parameter int Y_SHIFT = 0,
    parameter int CH_NUM  = 2,
    parameter int GRID_DX = 64,
    parameter int GRID_DY = 32,
    parameter int ADDR_W  = $clog2(WIN_W)
) (
    input  logic                     vga_clk,
    input  logic                     sys_rst_n,
    input  logic [11:0]              pix_x,
    input  logic [11:0]              pix_y,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic                     vec_mode,
    input  logic                     grid_en,
    input  logic [DATA_W-1:0]        trig_level,
    output logic                     wave_rd_en,
    output logic [ADDR_W-1:0]        wave_rd_addr,
    input  logic [CH_NUM*DATA_W-1:0] wave_rd_data,
    output logic [15:0]              pix_data_out
);

    localparam int SW    = DATA_W - Y_SHIFT;
    localparam int WIN_H = 2 ** SW;

    localparam logic [12:0] X_LO  = 13'(WIN_X0);
    localparam logic [12:0] X_HI  = 13'(WIN_X0 + WIN_W);
    localparam logic [12:0] Y_LO  = 13'(WIN_Y0);
    localparam logic [12:0] Y_HI  = 13'(WIN_Y0 + WIN_H);
    localparam logic [12:0] H_LIM = 13'(H_VALID);
    localparam logic [12:0] V_LIM = 13'(V_VALID);

    localparam logic [SW-1:0]     RY_TOP  = SW'(WIN_H - 1);
    localparam logic [ADDR_W-1:0] RX_LAST = ADDR_W'(WIN_W - 1);
    localparam logic [ADDR_W-1:0] GDX_M   = ADDR_W'(GRID_DX - 1);
    localparam logic [SW-1:0]     GDY_M   = SW'(GRID_DY - 1);

    localparam logic [15:0] C_ORANGE = 16'hFC00;
    localparam logic [15:0] C_WHITE  = 16'hFFFF;
    localparam logic [15:0] C_GRAY   = 16'hD69A;

    // Drop the Y_SHIFT LSBs so samples match the window height.
    function automatic logic [SW-1:0] scale(input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] sh;
        sh = raw >> Y_SHIFT;
        return sh[SW-1:0];
    endfunction

    // Fixed trace colour per channel index.
    function automatic logic [15:0] ch_colour(input int k);
        case (k)
            0:       return 16'hFFE0;
            1:       return 16'h07FF;
            2:       return 16'hF81F;
            default: return 16'h07E0;
        endcase
    endfunction

    // ---- stage 0: coordinate decode (combinational) ----
    logic [12:0]       x_p0, y_p0;
    logic              col_in_p0, row_in_p0, act_p0, frame_start_p0;
    logic [ADDR_W-1:0] rx_p0;
    logic [SW-1:0]     ry_inv_p0;

    assign x_p0           = {1'b0, pix_x};
    assign y_p0           = {1'b0, pix_y};
    assign col_in_p0      = (x_p0 >= X_LO) && (x_p0 < X_HI);
    assign row_in_p0      = (y_p0 >= Y_LO) && (y_p0 < Y_HI);
    assign act_p0         = (x_p0 < H_LIM) && (y_p0 < V_LIM);
    assign frame_start_p0 = (pix_x == 12'd0) && (pix_y == 12'd0);
    assign rx_p0          = ADDR_W'(x_p0 - X_LO);
    assign ry_inv_p0      = RY_TOP - SW'(y_p0 - Y_LO);

    logic [CH_NUM-1:0] sh_ch_en;
    logic              sh_vec, sh_grid;
    logic [DATA_W-1:0] sh_trig;

    // Latch display configuration once per frame so a frame is drawn consistently.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_ch_en <= '0;
            sh_vec   <= 1'b0;
            sh_grid  <= 1'b0;
            sh_trig  <= '0;
        end else if (frame_start_p0) begin
            sh_ch_en <= ch_en;
            sh_vec   <= vec_mode;
            sh_grid  <= grid_en;
            sh_trig  <= trig_level;
        end
    end

    // ---- stage 1: RAM request and window coordinates registered ----
    logic              vld_p1;
    logic [ADDR_W-1:0] rx_p1;
    logic [SW-1:0]     ry_p1;

    // Issue the column read and capture window-relative coordinates.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wave_rd_en   <= 1'b0;
            wave_rd_addr <= '0;
            vld_p1       <= 1'b0;
            rx_p1        <= '0;
            ry_p1        <= '0;
        end else begin
            wave_rd_en   <= col_in_p0 && (y_p0 < V_LIM);
            wave_rd_addr <= rx_p0;
            vld_p1       <= col_in_p0 && row_in_p0 && act_p0;
            rx_p1        <= rx_p0;
            ry_p1        <= ry_inv_p0;
        end
    end

    // ---- stage 2: control delayed to meet RAM read data ----
    logic              vld_p2;
    logic [ADDR_W-1:0] rx_p2;
    logic [SW-1:0]     ry_p2;

    // Align window coordinates with the RAM data returning this cycle.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p2 <= 1'b0;
            rx_p2  <= '0;
            ry_p2  <= '0;
        end else begin
            vld_p2 <= vld_p1;
            rx_p2  <= rx_p1;
            ry_p2  <= ry_p1;
        end
    end

    // ---- stage 3: trace compare, priority mux, output register ----
    logic [SW-1:0]     s_p2    [CH_NUM];
    logic [SW-1:0]     p_p2    [CH_NUM];
    logic [SW-1:0]     prev_p3 [CH_NUM];
    logic [CH_NUM-1:0] hit_p2;
    logic [15:0]       pix_nxt_p2;
    logic [SW-1:0]     t_p2;
    logic              hit_any_p2, border_p2, grid_p2;
    logic [15:0]       hit_col_p2;

    // Per-channel hit test and colour priority for the pixel leaving stage 2.
    always_comb begin
        hit_p2     = '0;
        hit_any_p2 = 1'b0;
        hit_col_p2 = 16'h0000;
        for (int k = 0; k < CH_NUM; k++) begin
            s_p2[k] = scale(wave_rd_data[k*DATA_W +: DATA_W]);
            p_p2[k] = (rx_p2 == '0) ? s_p2[k] : prev_p3[k];
            if (sh_vec)
                hit_p2[k] = ((ry_p2 >= s_p2[k]) || (ry_p2 >= p_p2[k])) &&
                            ((ry_p2 <= s_p2[k]) || (ry_p2 <= p_p2[k]));
            else
                hit_p2[k] = (s_p2[k] == ry_p2);
        end
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (sh_ch_en[k] && hit_p2[k]) begin
                hit_any_p2 = 1'b1;
                hit_col_p2 = ch_colour(k);
            end
        end
        t_p2      = scale(sh_trig);
        border_p2 = (rx_p2 == '0) || (rx_p2 == RX_LAST) ||
                    (ry_p2 == '0) || (ry_p2 == RY_TOP);
        grid_p2   = sh_grid && !rx_p2[1] &&
                    (((rx_p2 & GDX_M) == '0) || ((ry_p2 & GDY_M) == '0));
        if (!vld_p2)
            pix_nxt_p2 = 16'h0000;
        else if (hit_any_p2)
            pix_nxt_p2 = hit_col_p2;
        else if ((ry_p2 == t_p2) && !rx_p2[2])
            pix_nxt_p2 = C_ORANGE;
        else if (border_p2)
            pix_nxt_p2 = C_WHITE;
        else if (grid_p2)
            pix_nxt_p2 = C_GRAY;
        else
            pix_nxt_p2 = 16'h0000;
    end

    // Register the pixel and remember this column's samples for vector spans.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data_out <= 16'h0000;
            for (int k = 0; k < CH_NUM; k++) prev_p3[k] <= '0;
        end else begin
            pix_data_out <= pix_nxt_p2;
            if (vld_p2)
                for (int k = 0; k < CH_NUM; k++) prev_p3[k] <= s_p2[k];
        end
    end

endmodule
